ex_muldiv: RTL and testbench

// - Parametrised multi-cycle RV32M execute unit; sits beside the single-cycle EX ALU.
// - EX hands MUL/DIV/REM ops here via valid/ready. Result returns to the MEM-stage mux via valid/ready.
// - EX stalls while busy. Iterative datapath, XLEN/UNROLL cycles per op; divide special cases take one cycle.
//

---
 rtl/ex_muldiv_pkg.sv | 47 ++++
 rtl/ex_muldiv_if.sv | 38 +++
 rtl/ex_muldiv_div_step.sv | 22 ++
 rtl/ex_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants and op decode for the RV32M multi-cycle execute unit.
// funct3 codes, FSM encoding and the M-extension funct7 used by ex_ctrl.
package ex_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic is_div;
    logic a_sgn;
    logic b_sgn;
  } md_dec_t;

  function automatic md_dec_t md_decode(
    input logic [2:0] f3
  );
    md_dec_t d;
    d = '0;
    d.is_div = f3[2];
    unique case (f3)
      F3_MULH: begin
        d.a_sgn = 1'b1;
        d.b_sgn = 1'b1;
      end
      F3_MULHSU: d.a_sgn = 1'b1;
      F3_DIV, F3_REM: begin
        d.a_sgn = 1'b1;
        d.b_sgn = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response handshake between EX and the mul/div unit.
// master = EX side, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid,
    output funct3,
    output rs1,
    output rs2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result
  );

  modport slave (
    input  in_valid,
    input  funct3,
    input  rs1,
    input  rs2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result
  );

endinterface

// File: rtl/ex_muldiv_div_step.sv
// One combinational restoring-divide step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            dvd_bit,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  assign sh    = {rem, dvd_bit};
  assign diff  = sh - {1'b0, divisor};
  assign q_bit = ~diff[XLEN];
  assign rem_o = q_bit ? diff[XLEN-1:0]
                       : sh[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiply and
// restoring divide. Define MULDIV_FAST_MUL_EN for single-cycle MUL* ops.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ex_muldiv_if.slave  io,
  output logic        busy
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MIN_INT =
    {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        op;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   opb;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   result;

  assign io.in_ready   = (state == ST_IDLE);
  assign io.out_valid  = (state == ST_DONE);
  assign io.out_result = result;
  assign busy          = (state != ST_IDLE);

  md_dec_t         dec;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign dec   = md_decode(io.funct3);
  assign a_neg = dec.a_sgn & io.rs1[XLEN-1];
  assign b_neg = dec.b_sgn & io.rs2[XLEN-1];
  assign mag_a = a_neg ? -io.rs1 : io.rs1;
  assign mag_b = b_neg ? -io.rs2 : io.rs2;

  // Overflow only exists for the signed forms (funct3[0] clear).
  assign div0 = (io.rs2 == '0);
  assign ovf  = (io.rs1 == MIN_INT) & (&io.rs2)
              & ~io.funct3[0];
  assign special = dec.is_div & (div0 | ovf);

  always_comb begin
    special_res = '0;
    if (div0)
      special_res = io.funct3[1] ? io.rs1 : '1;
    else
      special_res = io.funct3[1] ? '0 : io.rs1;
  end

  logic            fast;
  logic [XLEN-1:0] fast_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] f_prod;
  logic [2*XLEN-1:0] f_sgn;

  assign f_prod = {{XLEN{1'b0}}, mag_a}
                * {{XLEN{1'b0}}, mag_b};
  assign f_sgn  = (a_neg ^ b_neg) ? -f_prod : f_prod;
  assign fast   = ~dec.is_div;
  assign fast_res = (io.funct3[1:0] == 2'b00)
                  ? f_sgn[XLEN-1:0]
                  : f_sgn[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  logic            short_op;
  logic [XLEN-1:0] short_res;

  assign short_op  = special | fast;
  assign short_res = special ? special_res : fast_res;

  // Multiply: p = {acc, multiplier}; opb is the multiplicand.
  logic [2*XLEN-1:0] m_p;
  logic [XLEN:0]     m_sum;

  always_comb begin
    m_p   = p;
    m_sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      m_sum = {1'b0, m_p[2*XLEN-1:XLEN]}
            + (m_p[0] ? {1'b0, opb} : '0);
      m_p = {m_sum, m_p[XLEN-1:1]};
    end
  end

  // Divide: p = {remainder, dividend/quotient}; opb is the divisor.
  logic [XLEN-1:0] d_rem [UNROLL+1];
  logic [XLEN-1:0] d_dq  [UNROLL+1];
  logic [UNROLL-1:0] q_bits;

  assign d_rem[0] = p[2*XLEN-1:XLEN];
  assign d_dq[0]  = p[XLEN-1:0];

  for (genvar g = 0; g < UNROLL; g++) begin : g_div
    muldiv_div_step #(
      .XLEN (XLEN)
    ) u_step (
      .rem     (d_rem[g]),
      .divisor (opb),
      .dvd_bit (d_dq[g][XLEN-1]),
      .rem_o   (d_rem[g+1]),
      .q_bit   (q_bits[g])
    );
    assign d_dq[g+1] = {d_dq[g][XLEN-2:0], q_bits[g]};
  end

  logic [2*XLEN-1:0] p_next;
  logic [2*XLEN-1:0] mul_s;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    p_next  = op[2] ? {d_rem[UNROLL], d_dq[UNROLL]} : m_p;
    mul_s   = neg_res ? -m_p : m_p;
    fin_res = '0;
    if (!op[2])
      fin_res = (op[1:0] == 2'b00) ? mul_s[XLEN-1:0]
                                   : mul_s[2*XLEN-1:XLEN];
    else if (op[1])
      fin_res = neg_rem ? -d_rem[UNROLL] : d_rem[UNROLL];
    else
      fin_res = neg_res ? -d_dq[UNROLL] : d_dq[UNROLL];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op      <= '0;
      cnt     <= '0;
      p       <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            op      <= io.funct3;
            p       <= {{XLEN{1'b0}}, mag_a};
            opb     <= mag_b;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= '0;
            if (short_op) begin
              result <= short_res;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= fin_res;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io.out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: UNROLL=1 and UNROLL=4 instances.
// Honours MULDIV_FAST_MUL_EN for the expected MUL* latency.
module tb_ex_muldiv;

  import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT1 = 1;
  localparam int MLAT4 = 1;
`else
  localparam int MLAT1 = 33;
  localparam int MLAT4 = 9;
`endif

  logic clk;
  logic rst_n;
  logic flush1;
  logic flush4;
  logic busy1;
  logic busy4;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_if #(.XLEN(32)) b1 ();
  ex_muldiv_if #(.XLEN(32)) b4 ();

  ex_muldiv #(.XLEN(32), .UNROLL(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush1),
    .io    (b1.slave),
    .busy  (busy1)
  );

  ex_muldiv #(.XLEN(32), .UNROLL(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush4),
    .io    (b4.slave),
    .busy  (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(
    input bit          sel,
    input logic        v,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (!sel) begin
      b1.in_valid = v;
      b1.funct3   = f3;
      b1.rs1      = a;
      b1.rs2      = b;
    end else begin
      b4.in_valid = v;
      b4.funct3   = f3;
      b4.rs1      = a;
      b4.rs2      = b;
    end
  endtask

  task automatic ordy(input bit sel, input logic v);
    if (!sel) b1.out_ready = v;
    else      b4.out_ready = v;
  endtask

  function automatic logic ov(input bit sel);
    return sel ? b4.out_valid : b1.out_valid;
  endfunction

  function automatic logic ir(input bit sel);
    return sel ? b4.in_ready : b1.in_ready;
  endfunction

  function automatic logic [31:0] res(input bit sel);
    return sel ? b4.out_result : b1.out_result;
  endfunction

  task automatic wait_done(
    input  bit sel,
    output int lat
  );
    lat = 1;
    while (!ov(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(
    input bit          sel,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp_res,
    input int          exp_lat,
    input string       tag
  );
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(ir(sel)), 32'd1);
    drv(sel, 1'b1, f3, a, b);
    @(negedge clk);
    drv(sel, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_done(sel, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk(tag, res(sel), exp_res);
    ordy(sel, 1'b1);
    @(negedge clk);
    ordy(sel, 1'b0);
    chk({tag, "_drain"}, 32'(ov(sel)), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    rst_n  = 1'b1;
    flush1 = 1'b0;
    flush4 = 1'b0;
    drv(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drv(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    ordy(1'b0, 1'b0);
    ordy(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_out_result", b1.out_result, 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, F3_MUL, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFEB, MLAT1, "mul");
    run_op(0, F3_MULH, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, MLAT1, "mulh");
    run_op(0, F3_MULHU, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, MLAT1, "mulhu");
    run_op(0, F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, MLAT1, "mulhsu");
    run_op(0, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, MLAT1, "mulhu_max");
    run_op(0, F3_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 33, "div");
    run_op(0, F3_REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 33, "rem");
    run_op(0, F3_DIVU, 32'd100, 32'd7,
           32'd14, 33, "divu");
    run_op(0, F3_REMU, 32'd100, 32'd7,
           32'd2, 33, "remu");
    run_op(0, F3_DIVU, 32'd5, 32'd0,
           32'hFFFF_FFFF, 1, "divu_by0");
    run_op(0, F3_REM, 32'd5, 32'd0,
           32'd5, 1, "rem_by0");
    run_op(0, F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1, "div_ovf");
    run_op(0, F3_REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1, "rem_ovf");

    // Back-pressure: result held, new requests ignored.
    @(negedge clk);
    drv(0, 1'b1, F3_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    drv(0, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_done(0, lat);
    chk("bp_lat", 32'(lat), 32'd33);
    drv(0, 1'b1, F3_DIVU, 32'd1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(b1.out_valid), 32'd1);
      chk("bp_result", b1.out_result, 32'd14);
      chk("bp_in_ready", 32'(b1.in_ready), 32'd0);
    end
    drv(0, 1'b0, 3'd0, 32'd0, 32'd0);
    ordy(0, 1'b1);
    @(negedge clk);
    ordy(0, 1'b0);
    chk("bp_release", 32'(b1.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_ghost", 32'(b1.out_valid), 32'd0);

    // Asynchronous reset mid-CALC.
    drv(0, 1'b1, F3_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    drv(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    chk("rc_busy_pre", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_in_ready", 32'(b1.in_ready), 32'd1);
    chk("rc_busy", 32'(busy1), 32'd0);
    chk("rc_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rc_out_result", b1.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, F3_REMU, 32'd100, 32'd7,
           32'd2, 33, "post_rst");

    // Flush mid-CALC: back to IDLE, never a result.
    @(negedge clk);
    drv(0, 1'b1, F3_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    drv(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    flush1 = 1'b1;
    @(negedge clk);
    flush1 = 1'b0;
    chk("fl_in_ready", 32'(b1.in_ready), 32'd1);
    chk("fl_busy", 32'(busy1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.out_valid) pulses++;
    end
    chk("fl_no_valid", 32'(pulses), 32'd0);

    // flush wins over in_valid in IDLE.
    drv(0, 1'b1, F3_DIVU, 32'd5, 32'd0);
    flush1 = 1'b1;
    @(negedge clk);
    drv(0, 1'b0, 3'd0, 32'd0, 32'd0);
    flush1 = 1'b0;
    chk("fi_busy", 32'(busy1), 32'd0);
    chk("fi_in_ready", 32'(b1.in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b1.out_valid) pulses++;
    end
    chk("fi_no_valid", 32'(pulses), 32'd0);

    // UNROLL=4 instance.
    run_op(1, F3_DIVU, 32'hFFFF_FFFF, 32'd3,
           32'h5555_5555, 9, "u4_divu");
    run_op(1, F3_REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 9, "u4_rem");
    run_op(1, F3_MUL, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFEB, MLAT4, "u4_mul");
    run_op(1, F3_MULH, 32'hFFFF_FFF9, 32'd3,
           32'hFFFF_FFFF, MLAT4, "u4_mulh");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
